// File: rtl/read_sram_fetch.sv
// Read-side master for a 2-cycle-latency single-port SRAM: streams a contiguous
// word range through a credit-limited latency pipe into a small output FIFO.
module read_sram_fetch #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 64,
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clka,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_words,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] sram_addra,
   output logic              sram_wea,
   output logic [DATA_W-1:0] sram_dina,
   input  logic [DATA_W-1:0] sram_douta,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_last
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] addr_cnt;
   logic [ADDR_W-1:0] addr_hold;
   logic [ADDR_W:0]   remain;
   logic [LATENCY-1:0] vld_pipe;
   logic [LATENCY-1:0] last_pipe;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       credit_used;
   logic              issue;
   logic              capture;
   logic              pop;
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   assign sram_wea    = 1'b0;
   assign sram_dina   = DATA_W'(0);
   assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
   assign capture     = vld_pipe[LATENCY-1];
   assign rd_valid    = (fifo_count != CW'(0));
   assign pop         = rd_valid & rd_ready;
   assign rd_data     = fifo_data[rd_ptr];
   assign rd_last     = rd_valid & fifo_last[rd_ptr];

   // State register; busy/done registered from the upcoming state
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != S_IDLE);
         done  <= (next_state == S_DONE);
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = (num_words == (ADDR_W+1)'(0)) ? S_DONE : S_FETCH;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_FETCH: begin
            if (issue && (remain == (ADDR_W+1)'(1))) begin
               next_state = S_DRAIN;
            end else begin
               next_state = S_FETCH;
            end
         end
         // The last-tagged word is only in the FIFO once the pipe holds nothing more
         S_DRAIN: begin
            if ((inflight == CW'(0)) && pop && rd_last) begin
               next_state = S_DONE;
            end else begin
               next_state = S_DRAIN;
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Issue decision and SRAM address; credits cover everything issued or buffered
   always_comb begin
      issue      = 1'b0;
      sram_addra = addr_hold;
      if ((state == S_FETCH) && (remain != (ADDR_W+1)'(0)) &&
          (credit_used < (CW+1)'(FIFO_DEPTH))) begin
         issue      = 1'b1;
         sram_addra = addr_cnt;
      end else begin
         issue      = 1'b0;
         sram_addra = addr_hold;
      end
   end

   // Address/remaining counters, latency pipe and in-flight count
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         addr_cnt  <= ADDR_W'(0);
         addr_hold <= ADDR_W'(0);
         remain    <= (ADDR_W+1)'(0);
         vld_pipe  <= LATENCY'(0);
         last_pipe <= LATENCY'(0);
         inflight  <= CW'(0);
      end else begin
         if ((state == S_IDLE) && start) begin
            addr_cnt <= base_addr;
            remain   <= num_words;
         end else if (issue) begin
            addr_cnt  <= addr_cnt + ADDR_W'(1);
            remain    <= remain - (ADDR_W+1)'(1);
            addr_hold <= addr_cnt;
         end
         vld_pipe[0]  <= issue;
         last_pipe[0] <= issue & (remain == (ADDR_W+1)'(1));
         for (int i = 1; i < LATENCY; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            last_pipe[i] <= last_pipe[i-1];
         end
         case ({issue, capture})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Output FIFO storage and pointers
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         wr_ptr     <= PW'(0);
         rd_ptr     <= PW'(0);
         fifo_count <= CW'(0);
         fifo_last  <= FIFO_DEPTH'(0);
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= DATA_W'(0);
         end
      end else begin
         if (capture) begin
            fifo_data[wr_ptr] <= sram_douta;
            fifo_last[wr_ptr] <= last_pipe[LATENCY-1];
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({capture, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   read_sram_fetch_chk u_chk (
      .clka    (clka),
      .rst     (rst),
      .capture (capture),
      .pop     (pop),
      .full    (fifo_count == CW'(FIFO_DEPTH))
   );
endmodule

// Capture into a full FIFO without a same-cycle pop means the credit rule broke.
module read_sram_fetch_chk (
   input logic clka,
   input logic rst,
   input logic capture,
   input logic pop,
   input logic full
);
   a_no_overflow : assert property (@(posedge clka) disable iff (rst)
      !(capture && full && !pop))
      else $error("read_sram_fetch: FIFO overflow on capture");
endmodule

// File: tb/tb_read_sram_fetch.sv
// Self-checking bench for read_sram_fetch: 2-cycle SRAM model plus a word
// scoreboard built from the command (base + k mod 1024, last on final word).
module tb_read_sram_fetch;
   logic        clka = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  base_addr;
   logic [10:0] num_words;
   logic        busy;
   logic        done;
   logic [9:0]  sram_addra;
   logic        sram_wea;
   logic [63:0] sram_dina;
   logic [63:0] sram_douta;
   logic [63:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        rd_last;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0] mem [1024];
   logic [9:0]  addr_q;

   read_sram_fetch dut (
      .clka       (clka),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .num_words  (num_words),
      .busy       (busy),
      .done       (done),
      .sram_addra (sram_addra),
      .sram_wea   (sram_wea),
      .sram_dina  (sram_dina),
      .sram_douta (sram_douta),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_last    (rd_last)
   );

   always #5 clka = ~clka;

   // SRAM: registered address, then registered data
   always @(posedge clka) begin
      addr_q     <= sram_addra;
      sram_douta <= mem[addr_q];
   end

   // mode 0: ready always 1; mode 1: random ready + stray starts; mode 2: ready 0 until cycle 16
   task automatic run_stream(input logic [9:0] b, input int n, input int mode, input int budget,
                             output int first_hs, output int last_hs, output int done_c,
                             output int busy_cnt);
      logic [63:0] exp_d[$];
      logic        exp_l[$];
      logic [63:0] prev_d;
      logic        prev_l;
      logic        prev_stall;
      int          c;
      first_hs = -1; last_hs = -1; done_c = -1; busy_cnt = 0;
      prev_stall = 1'b0; prev_d = 64'd0; prev_l = 1'b0;
      for (int k = 0; k < n; k++) begin
         exp_d.push_back(64'((int'(b) + k) % 1024));
         exp_l.push_back(k == n - 1);
      end
      base_addr = b;
      num_words = 11'(n);
      c = 0;
      while (c < budget && done_c < 0) begin
         if (c == 0) start = 1'b1;
         else if (mode == 1) start = ($urandom_range(0, 7) == 0);
         else start = 1'b0;
         if (start && c != 0) begin
            base_addr = 10'($urandom);
            num_words = 11'($urandom_range(0, 20));
         end
         case (mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = 1'($urandom_range(0, 1));
            default: rd_ready = (c >= 16);
         endcase
         @(negedge clka);
         if (busy) busy_cnt++;
         n_cmp++;
         if ({sram_wea, sram_dina} !== 65'd0) begin
            n_fail++;
            $display("FAIL write_tie: cycle %0d wea=%0b dina=%h, want 0", c, sram_wea, sram_dina);
         end
         if (prev_stall) begin
            n_cmp++;
            if ({rd_valid, rd_last, rd_data} !== {1'b1, prev_l, prev_d}) begin
               n_fail++;
               $display("FAIL stall_stable: cycle %0d got v=%0b l=%0b d=%0d, want v=1 l=%0b d=%0d",
                        c, rd_valid, rd_last, rd_data, prev_l, prev_d);
            end
         end
         if (rd_valid && rd_ready) begin
            if (first_hs < 0) first_hs = c;
            if (rd_last) last_hs = c;
            n_cmp++;
            if (exp_d.size() == 0) begin
               n_fail++;
               $display("FAIL extra_word: cycle %0d got d=%0d, want no word", c, rd_data);
            end else begin
               if (rd_data !== exp_d[0] || rd_last !== exp_l[0]) begin
                  n_fail++;
                  $display("FAIL word: cycle %0d got d=%0d last=%0b, want d=%0d last=%0b",
                           c, rd_data, rd_last, exp_d[0], exp_l[0]);
               end
               void'(exp_d.pop_front());
               void'(exp_l.pop_front());
            end
         end
         if (mode == 2 && c == 15) begin
            n_cmp++;
            if (sram_addra !== b + 10'd3 || rd_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL credit_stall: addr=%0d valid=%0b, want addr=%0d valid=1",
                        sram_addra, rd_valid, b + 10'd3);
            end
         end
         if (done) begin
            done_c = c;
            n_cmp++;
            if (exp_d.size() != 0 || last_hs != c - 1) begin
               n_fail++;
               $display("FAIL done_timing: cycle %0d left=%0d last_hs=%0d, want left=0 last_hs=%0d",
                        c, exp_d.size(), last_hs, c - 1);
            end
         end
         prev_stall = rd_valid && !rd_ready;
         prev_d = rd_data;
         prev_l = rd_last;
         @(posedge clka); #1;
         start = 1'b0;
         c++;
      end
      if (done_c < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout: no done within %0d cycles, %0d words outstanding", budget, exp_d.size());
      end
      @(negedge clka);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: after done got done=%0b busy=%0b, want 0 0", done, busy);
      end
      @(posedge clka); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; rd_ready = 1'b0; base_addr = 10'd0; num_words = 11'd0;
      #1;
      @(posedge clka); #1;
      @(negedge clka);
      n_cmp++;
      if ({busy, done, rd_valid, rd_last} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: busy=%0b done=%0b valid=%0b last=%0b, want all 0",
                  busy, done, rd_valid, rd_last);
      end
      n_cmp++;
      if (sram_addra !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_addr: got %0d, want 0", sram_addra);
      end
      @(posedge clka); #1;
      rst = 1'b0;
      @(posedge clka); #1;
   endtask

   task automatic test_basic();
      int f, l, d, bc;
      run_stream(10'd5, 8, 0, 100, f, l, d, bc);
      n_cmp++;
      if (f !== 4 || l !== 11 || d !== 12 || bc !== 12) begin
         n_fail++;
         $display("FAIL basic_timing: first=%0d last=%0d done=%0d busy_cycles=%0d, want 4 11 12 12",
                  f, l, d, bc);
      end
   endtask

   task automatic test_backpressure();
      int f, l, d, bc;
      run_stream(10'd5, 8, 2, 300, f, l, d, bc);
      n_cmp++;
      if (f !== 16) begin
         n_fail++;
         $display("FAIL bp_first: first handshake cycle %0d, want 16", f);
      end
   endtask

   task automatic test_wrap();
      int f, l, d, bc;
      run_stream(10'd1022, 4, 0, 100, f, l, d, bc);
      n_cmp++;
      if (f !== 4 || d !== 8) begin
         n_fail++;
         $display("FAIL wrap_timing: first=%0d done=%0d, want 4 8", f, d);
      end
   endtask

   task automatic test_zero();
      logic [9:0] a0;
      a0 = sram_addra;
      base_addr = 10'd7; num_words = 11'd0; rd_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         start = (c == 0);
         @(negedge clka);
         n_cmp++;
         if (done !== (c == 1) || busy !== (c == 1) || rd_valid !== 1'b0 || sram_addra !== a0) begin
            n_fail++;
            $display("FAIL zero_cmd: cycle %0d done=%0b busy=%0b valid=%0b addr=%0d, want %0b %0b 0 %0d",
                     c, done, busy, rd_valid, sram_addra, c == 1, c == 1, a0);
         end
         @(posedge clka); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid();
      int f, l, d, bc;
      base_addr = 10'd5; num_words = 11'd8; rd_ready = 1'b0;
      start = 1'b1;
      @(posedge clka); #1;
      start = 1'b0;
      @(posedge clka); #1;
      @(posedge clka); #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, rd_valid, rd_last} !== 4'b0000 || sram_addra !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%0b done=%0b valid=%0b last=%0b addr=%0d, want 0",
                  busy, done, rd_valid, rd_last, sram_addra);
      end
      @(posedge clka); #1;
      rst = 1'b0;
      rd_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clka);
         n_cmp++;
         if (rd_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_word: cycle %0d after reset valid=%0b busy=%0b, want 0 0",
                     c, rd_valid, busy);
         end
         @(posedge clka); #1;
      end
      run_stream(10'd0, 3, 0, 100, f, l, d, bc);
      n_cmp++;
      if (f !== 4 || l !== 6 || d !== 7) begin
         n_fail++;
         $display("FAIL restart_timing: first=%0d last=%0d done=%0d, want 4 6 7", f, l, d);
      end
   endtask

   task automatic test_random();
      int f, l, d, bc;
      run_stream(10'($urandom), 200, 1, 3000, f, l, d, bc);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 64'(i);
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
